sine_monitor: RTL and testbench

Receive-side checker for the 33-bit active-low thermometer sine bus produced by the digital sine generator. It converts the thermometer back to a 6-bit level and flags malformed (bubbled) codes. It tracks waveform direction, emits peak/trough pulses and measures the trough-to-trough period in clock cycles. It sits on the same clock as the generator and feeds loopback self-test and status registers.

---
 rtl/sine_monitor_if.sv | 29 ++
 rtl/sine_monitor.sv | 196 +++++++++++++++++++
 tb/tb_sine_monitor.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_monitor_if.sv
// Sample/status bundle between the sine receive path and sine_monitor.
// The master drives the thermometer sample and its controls; the slave
// (sine_monitor) returns the decoded level, error flags and period results.
interface sine_monitor_if #(
  parameter int unsigned PERIOD_W = 16
);
  logic                enable;
  logic                clear;
  logic [32:0]         therm_n;
  logic [5:0]          level;
  logic                valid;
  logic                bubble_err;
  logic                step_err;
  logic                dir;
  logic                peak;
  logic                trough;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport master (
    output enable, clear, therm_n,
    input  level, valid, bubble_err, step_err, dir, peak, trough, period, period_valid
  );

  modport slave (
    input  enable, clear, therm_n,
    output level, valid, bubble_err, step_err, dir, peak, trough, period, period_valid
  );
endinterface

// File: rtl/sine_monitor.sv
// Receive-side checker for the 33-bit active-low thermometer sine bus.
// Decodes the level, flags bubbled codes, tracks waveform direction, pulses on
// peaks/troughs and measures trough-to-trough period in clock cycles.
// Optional feature macro: SINE_MON_STEP_CHECK_EN builds the |delta|>1 step check;
// without it step_err is held at 0.
module sine_monitor #(
  parameter int unsigned PERIOD_W = 16
) (
  input logic           clk,
  input logic           rst,
  sine_monitor_if.slave bus
);

  localparam int unsigned TW = 33;
  localparam int unsigned LW = 6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RISING  = 2'd1;
  localparam logic [1:0] ST_FALLING = 2'd2;

  logic [TW-1:0]       t_q;
  logic                v1_q;
  logic [LW-1:0]       level_c;
  logic                bubble_c;
  logic [LW-1:0]       level_q;
  logic                valid_q;
  logic                bubble_q;
  logic                bubble_err_q;
  logic [LW-1:0]       prev_q;
  logic                have_q;
  logic                accept_c;
  logic                rise_c;
  logic                fall_c;
  logic                step_c;
  logic                step_err_q;
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                peak_c;
  logic                trough_c;
  logic                dir_q;
  logic                peak_q;
  logic                trough_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                running_q;
  logic [PERIOD_W-1:0] period_q;
  logic                period_valid_q;

  // Stage 1: capture the inverted thermometer when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= bus.enable;
      if (bus.enable) t_q <= ~bus.therm_n;
    end
  end

  // Popcount and contiguity check of the captured thermometer.
  always_comb begin
    level_c  = '0;
    bubble_c = 1'b0;
    for (int i = 0; i < int'(TW); i++) level_c = level_c + LW'(t_q[i]);
    for (int i = 0; i < int'(TW) - 1; i++) bubble_c = bubble_c | (t_q[i+1] & ~t_q[i]);
  end

  // Stage 2: register level/valid and the sticky bubble flag (clear wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q      <= '0;
      valid_q      <= 1'b0;
      bubble_q     <= 1'b0;
      bubble_err_q <= 1'b0;
    end else begin
      level_q  <= level_c;
      valid_q  <= v1_q;
      bubble_q <= bubble_c;
      if (bus.clear)               bubble_err_q <= 1'b0;
      else if (v1_q && bubble_c)   bubble_err_q <= 1'b1;
    end
  end

  // Stage 3 qualifiers: only clean, valid samples with a reference level count.
  assign accept_c = valid_q & ~bubble_q;
  assign rise_c   = accept_c & have_q & (level_q > prev_q);
  assign fall_c   = accept_c & have_q & (level_q < prev_q);

`ifdef SINE_MON_STEP_CHECK_EN
  assign step_c = accept_c & have_q &
                  ((level_q > prev_q + LW'(1)) | (prev_q > level_q + LW'(1)));
`else
  assign step_c = 1'b0;
`endif

  // Direction FSM next state and peak/trough decisions.
  always_comb begin
    state_d  = state_q;
    peak_c   = 1'b0;
    trough_c = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c)      state_d = ST_RISING;
          else if (fall_c) state_d = ST_FALLING;
        end
        ST_RISING: begin
          if (fall_c) begin
            state_d = ST_FALLING;
            peak_c  = 1'b1;
          end
        end
        ST_FALLING: begin
          if (rise_c) begin
            state_d  = ST_RISING;
            trough_c = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register with registered direction and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= (state_d == ST_RISING);
      peak_q   <= peak_c;
      trough_q <= trough_c;
    end
  end

  // Last accepted level and the sticky step flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q     <= '0;
      have_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else if (bus.clear) begin
      prev_q     <= '0;
      have_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      if (accept_c) begin
        prev_q <= level_q;
        have_q <= 1'b1;
      end
      if (step_c) step_err_q <= 1'b1;
    end
  end

  // Trough-to-trough period counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      running_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (bus.clear) begin
      cnt_q          <= '0;
      running_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (trough_c) begin
        cnt_q     <= PERIOD_W'(1);
        running_q <= 1'b1;
        if (running_q) begin
          period_q       <= cnt_q;
          period_valid_q <= 1'b1;
        end
      end else if (running_q && (cnt_q != {PERIOD_W{1'b1}})) begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign bus.level        = level_q;
  assign bus.valid        = valid_q;
  assign bus.bubble_err   = bubble_err_q;
  assign bus.step_err     = step_err_q;
  assign bus.dir          = dir_q;
  assign bus.peak         = peak_q;
  assign bus.trough       = trough_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_sine_monitor.sv
// Scoreboard bench for sine_monitor: stimulus pushes expected results from a
// behavioural model, a negedge monitor pops and compares as outputs appear.
// A second instance with a 4-bit period checks counter saturation.
module tb_sine_monitor;

  localparam int unsigned PW  = 16;
  localparam int unsigned SPW = 4;
`ifdef SINE_MON_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sine_monitor_if #(.PERIOD_W(PW))  bus ();
  sine_monitor_if #(.PERIOD_W(SPW)) sbus ();

  assign sbus.enable  = bus.enable;
  assign sbus.clear   = bus.clear;
  assign sbus.therm_n = bus.therm_n;

  sine_monitor #(.PERIOD_W(PW))  u_dut   (.clk(clk), .rst(rst), .bus(bus));
  sine_monitor #(.PERIOD_W(SPW)) u_small (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    int cyc;
    int lvl;
    bit bub;
    bit berr;
  } s2_t;

  typedef struct {
    bit dir;
    bit pk;
    bit tr;
    bit step;
    bit pv;
    int per;
    int sper;
  } s3_t;

  s2_t q2[$];
  s3_t q3[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Behavioural model state: direction is the sign of the last nonzero change.
  bit m_berr, m_step, m_have, m_trv;
  int m_prev, m_dirn, m_lasttr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_berr = 0; m_step = 0; m_have = 0; m_trv = 0;
    m_prev = 0; m_dirn = 0; m_lasttr = 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [32:0] therm_of(input int l);
    logic [33:0] x;
    x = (34'd1 << l) - 34'd1;
    return ~x[32:0];
  endfunction

  function automatic void model_sample(input logic [32:0] tn, input int c);
    logic [32:0] t;
    int  lvl, d;
    bit  bub;
    s3_t e;
    t   = ~tn;
    lvl = $countones(t);
    bub = ((t & (t + 33'd1)) != 33'd0);
    if (bub) m_berr = 1;
    q2.push_back('{c, lvl, bub, m_berr});
    if (!bub) begin
      e = '{default: 0};
      if (m_have) begin
        d = lvl - m_prev;
        if (STEP_EN && (d > 1 || d < -1)) m_step = 1;
        if (d < 0 && m_dirn == 1) e.pk = 1;
        if (d > 0 && m_dirn == -1) begin
          e.tr = 1;
          if (m_trv) begin
            e.pv   = 1;
            e.per  = imin(c - m_lasttr, (1 << PW) - 1);
            e.sper = imin(c - m_lasttr, (1 << SPW) - 1);
          end
          m_trv    = 1;
          m_lasttr = c;
        end
        if (d > 0)      m_dirn = 1;
        else if (d < 0) m_dirn = -1;
      end
      m_have = 1;
      m_prev = lvl;
      e.dir  = (m_dirn == 1);
      e.step = m_step;
      q3.push_back(e);
    end
  endfunction

  task automatic drive(input bit en, input bit clr, input logic [32:0] tn);
    @(posedge clk);
    #1;
    bus.enable  = en;
    bus.clear   = clr;
    bus.therm_n = tn;
    if (clr) model_reset();
    if (en) model_sample(tn, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, {1'($urandom), $urandom});
  endtask

  task automatic lvl(input int l);
    drive(1'b1, 1'b0, therm_of(l));
  endtask

  task automatic do_clear();
    idle(4);
    drive(1'b0, 1'b1, '1);
    drive(1'b0, 1'b0, '1);
    @(negedge clk);
    check("clear_bubble_err", bus.bubble_err, 0);
    check("clear_step_err", bus.step_err, 0);
    check("clear_dir", bus.dir, 0);
    check("clear_period", bus.period, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_bubble_err"}, bus.bubble_err, 0);
    check({tag, "_step_err"}, bus.step_err, 0);
    check({tag, "_dir"}, bus.dir, 0);
    check({tag, "_peak"}, bus.peak, 0);
    check({tag, "_trough"}, bus.trough, 0);
    check({tag, "_period"}, bus.period, 0);
    check({tag, "_period_valid"}, bus.period_valid, 0);
    check({tag, "_small_period"}, sbus.period, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    q2.delete();
    q3.delete();
    model_reset();
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: pop expected results as the DUT presents them.
  bit  pend = 0;
  s2_t s2;
  s3_t s3;
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        if (q3.size() == 0) begin
          check("stage3_queue_empty", 1, 0);
        end else begin
          s3 = q3.pop_front();
          check("dir", bus.dir, s3.dir);
          check("peak", bus.peak, s3.pk);
          check("trough", bus.trough, s3.tr);
          check("step_err", bus.step_err, s3.step);
          check("period_valid", bus.period_valid, s3.pv);
          check("small_period_valid", sbus.period_valid, s3.pv);
          if (s3.pv) begin
            check("period", bus.period, s3.per);
            check("small_period", sbus.period, s3.sper);
          end
        end
      end else begin
        check("peak_quiet", bus.peak, 0);
        check("trough_quiet", bus.trough, 0);
        check("period_valid_quiet", bus.period_valid, 0);
      end
      if (bus.valid) begin
        if (q2.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          s2 = q2.pop_front();
          check("valid_latency", cyc, s2.cyc + 2);
          check("level", bus.level, s2.lvl);
          check("bubble_err", bus.bubble_err, s2.berr);
          if (!s2.bub) pend = 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv;
    bus.enable  = 1'b0;
    bus.clear   = 1'b0;
    bus.therm_n = '1;
    model_reset();
    #1 rst = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Decode and bubble handling.
    drive(1'b1, 1'b0, 33'h1FFFFFFFF);
    drive(1'b1, 1'b0, 33'h1FFFFFFF0);
    drive(1'b1, 1'b0, 33'h1FFFFFFF5);
    idle(2);
    lvl(4);
    lvl(3);
    do_clear();

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++) lvl(i);
    mid_reset();
    idle(2);

    // Full-swing triangle: peaks at 33, period 66 (small instance saturates at 15).
    do_clear();
    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < 33; l++) lvl(l);
      for (int l = 33; l > 0; l--) lvl(l);
    end
    lvl(0);
    lvl(1);

    // Short triangle: troughs 20 cycles apart.
    do_clear();
    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < 10; l++) lvl(l);
      for (int l = 10; l > 0; l--) lvl(l);
    end
    lvl(0);
    lvl(1);

    // Step error: 5 then 8.
    do_clear();
    lvl(5);
    lvl(8);
    idle(3);
    check("step_after_jump", bus.step_err, STEP_EN);

    // Plateau with enable gaps.
    do_clear();
    lvl(10); idle(1);
    lvl(11); idle(1);
    lvl(11); idle(1);
    lvl(11); idle(1);
    lvl(12); idle(1);

    // Random walk with gaps, jumps and malformed codes.
    do_clear();
    lv = 16;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        idle(1);
      end else if (r < 25) begin
        drive(1'b1, 1'b0, {1'($urandom), $urandom});
      end else begin
        if (r < 28)      lv = int'($urandom_range(0, 33));
        else if (r < 60) lv = (lv < 33) ? lv + 1 : lv - 1;
        else if (r < 92) lv = (lv > 0) ? lv - 1 : lv + 1;
        lvl(lv);
      end
    end

    idle(4);
    check("stage2_drained", q2.size(), 0);
    check("stage3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
